counters_updown_multi: RTL



---
 rtl/counters_updown_multi.sv | 135 +++++++++++++
 1 files changed

// File: rtl/counters_updown_multi.sv
// Multi-channel signed up/down event counters with saturate-or-wrap overflow handling
// and a snapshot-and-drain readout streamed one channel per valid/ready transfer.
module counters_updown_multi #(
  parameter int unsigned size_code = 8,
  parameter int unsigned num_ch    = 4,
  parameter int unsigned saturate  = 1,
  localparam int unsigned chw      = (num_ch > 1) ? $clog2(num_ch) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [num_ch-1:0]    bitin,
  input  logic [num_ch-1:0]    sign,
  input  logic                 clear,
  input  logic                 drain_start,
  output logic                 drain_busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [size_code-1:0] out_data,
  output logic [chw-1:0]       out_ch,
  output logic                 out_ovf,
  output logic [num_ch-1:0]    overflow
);

  typedef enum logic {st_idle, st_drain} state_t;

  localparam logic [size_code-1:0] cmax     = {1'b0, {(size_code-1){1'b1}}};
  localparam logic [size_code-1:0] cmin     = {1'b1, {(size_code-1){1'b0}}};
  localparam logic [size_code-1:0] one      = size_code'(1);
  localparam logic [chw-1:0]       last_idx = chw'(num_ch - 1);
  localparam logic [chw-1:0]       idx_one  = chw'(1);

  state_t               state, state_nxt;
  logic [chw-1:0]       idx, idx_nxt;
  logic [size_code-1:0] cnt     [num_ch];
  logic [size_code-1:0] cnt_nxt [num_ch];
  logic [size_code-1:0] shadow  [num_ch];
  logic [num_ch-1:0]    ovf_nxt;
  logic [num_ch-1:0]    shadow_ovf;
  logic                 snap;

  // A snapshot needs IDLE and loses to clear; the step then lands on a zeroed base.
  assign snap = (state == st_idle) && drain_start && !clear;

  always_comb begin
    ovf_nxt = snap ? '0 : overflow;
    for (int unsigned i = 0; i < num_ch; i++) begin
      cnt_nxt[i] = snap ? '0 : cnt[i];
      if (enable && bitin[i]) begin
        if (!sign[i]) begin
          if (cnt_nxt[i] == cmax) begin
            ovf_nxt[i] = 1'b1;
            cnt_nxt[i] = (saturate != 0) ? cmax : cmin;
          end else begin
            cnt_nxt[i] = cnt_nxt[i] + one;
          end
        end else begin
          if (cnt_nxt[i] == cmin) begin
            ovf_nxt[i] = 1'b1;
            cnt_nxt[i] = (saturate != 0) ? cmin : cmax;
          end else begin
            cnt_nxt[i] = cnt_nxt[i] - one;
          end
        end
      end
    end
    if (clear) begin
      for (int unsigned i = 0; i < num_ch; i++) begin
        cnt_nxt[i] = '0;
      end
      ovf_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < num_ch; i++) begin
        cnt[i]    <= '0;
        shadow[i] <= '0;
      end
      overflow   <= '0;
      shadow_ovf <= '0;
    end else begin
      for (int unsigned i = 0; i < num_ch; i++) begin
        cnt[i] <= cnt_nxt[i];
        if (snap) begin
          shadow[i] <= cnt[i];
        end
      end
      overflow <= ovf_nxt;
      if (snap) begin
        shadow_ovf <= overflow;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= st_idle;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      st_idle: begin
        if (snap) begin
          state_nxt = st_drain;
          idx_nxt   = '0;
        end
      end
      st_drain: begin
        if (out_ready) begin
          if (idx == last_idx) begin
            state_nxt = st_idle;
          end else begin
            idx_nxt = idx + idx_one;
          end
        end
      end
    endcase
  end

  assign drain_busy = (state == st_drain);
  assign out_valid  = (state == st_drain);
  assign out_ch     = idx;
  assign out_data   = shadow[idx];
  assign out_ovf    = shadow_ovf[idx];

endmodule
